// File: rtl/exec_sequencer_if.sv
// Handshake bundle between the decode side and the execute sequencer.
// Carries offer/ready, execute enable, retire strobe and flush/redirect.
interface exec_sequencer_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_PC;
    logic        IN_IS_MC;
    logic        IN_IS_CTRL;
    logic [31:0] JUMP_DEST;
    logic        EXEC_EN;
    logic        OUT_VALID;
    logic        FLUSH;
    logic [31:0] REDIRECT_PC;

    modport master (
        output IN_VALID, IN_PC, IN_IS_MC, IN_IS_CTRL, JUMP_DEST,
        input  IN_READY, EXEC_EN, OUT_VALID, FLUSH, REDIRECT_PC
    );

    modport slave (
        input  IN_VALID, IN_PC, IN_IS_MC, IN_IS_CTRL, JUMP_DEST,
        output IN_READY, EXEC_EN, OUT_VALID, FLUSH, REDIRECT_PC
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: holds one instruction through execute,
// retires it, and flushes the front end on a taken control transfer.
// Ports: CLK, RST (sync, active-high), bus (exec_sequencer_if.slave):
//   IN_VALID/IN_READY/IN_PC/IN_IS_MC/IN_IS_CTRL  instruction offer
//   JUMP_DEST  next-PC from datapath, EXEC_EN  datapath enable
//   OUT_VALID  retire strobe, FLUSH/REDIRECT_PC  front-end redirect
// Macro EXEC_SEQ_MC_EN builds multi-cycle support (WAIT + counter).
module exec_sequencer #(
    parameter int MC_LAT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    exec_sequencer_if.slave   bus
);

`ifdef EXEC_SEQ_MC_EN
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] dest_q;
    logic        ctrl_q;
    logic        exec_en;
    logic        in_ready;
    logic        retire;
    logic        taken;
    logic        flush;
    logic        latch;

`ifdef EXEC_SEQ_MC_EN
    localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);
    logic        mc_q;
    logic [3:0]  cnt_q;
`endif

    assign in_ready = (state_q == IDLE) || (state_q == DONE);
    assign retire   = (state_q == DONE);
    assign taken    = ctrl_q && (dest_q != pc_q + 32'd1);
    assign flush    = retire && taken;
    // A taken retire kills whatever is offered alongside it.
    assign latch    = bus.IN_VALID && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        exec_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (latch) state_d = EXEC;
            end
            EXEC: begin
                exec_en = 1'b1;
                state_d = DONE;
`ifdef EXEC_SEQ_MC_EN
                if (mc_q) state_d = WAIT;
`endif
            end
`ifdef EXEC_SEQ_MC_EN
            WAIT: begin
                exec_en = 1'b1;
                if (cnt_q == 4'd0) state_d = DONE;
            end
`endif
            DONE: begin
                state_d = latch ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ctrl_q  <= 1'b0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                pc_q   <= bus.IN_PC;
                ctrl_q <= bus.IN_IS_CTRL;
            end
            if (exec_en) dest_q <= bus.JUMP_DEST;
        end
    end

`ifdef EXEC_SEQ_MC_EN
    // EXEC is the first execute cycle, so WAIT covers MC_LAT-1 more.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mc_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (latch) mc_q <= bus.IN_IS_MC;
            if (state_q == EXEC && state_d == WAIT)
                cnt_q <= CNT_INIT;
            else if (state_q == WAIT && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
        end
    end
`endif

    assign bus.IN_READY    = in_ready;
    assign bus.EXEC_EN     = exec_en;
    assign bus.OUT_VALID   = retire;
    assign bus.FLUSH       = flush;
    assign bus.REDIRECT_PC = flush ? dest_q : 32'd0;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: latency, flush, wrap-around,
// dropped offer on taken retire, mid-op reset and back-to-back ops.
module tb_exec_sequencer;

    localparam int MC_LAT = 4;
`ifdef EXEC_SEQ_MC_EN
    localparam int MC_CYC = MC_LAT;
    localparam int RST_AT = 3;
`else
    localparam int MC_CYC = 1;
    localparam int RST_AT = 1;
`endif

    logic CLK = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_bad = 0;

    exec_sequencer_if bus ();

    exec_sequencer #(.MC_LAT(MC_LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy,
                           input logic en, input logic ov,
                           input logic fl, input logic [31:0] rp);
        chk({tag, ".rdy"}, 32'(bus.IN_READY), 32'(rdy));
        chk({tag, ".en"}, 32'(bus.EXEC_EN), 32'(en));
        chk({tag, ".ov"}, 32'(bus.OUT_VALID), 32'(ov));
        chk({tag, ".fl"}, 32'(bus.FLUSH), 32'(fl));
        chk({tag, ".rp"}, bus.REDIRECT_PC, rp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] pc,
                          input logic mc, input logic ctrl,
                          input logic [31:0] dest, input logic exp_fl,
                          input logic drop_offer);
        int lat;
        lat = mc ? MC_CYC : 1;
        bus.IN_VALID   = 1'b1;
        bus.IN_PC      = pc;
        bus.IN_IS_MC   = mc;
        bus.IN_IS_CTRL = ctrl;
        bus.JUMP_DEST  = dest;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk_out({tag, ".ex"}, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            @(negedge CLK);
        end
        chk_out({tag, ".done"}, 1'b1, 1'b0, 1'b1, exp_fl,
                exp_fl ? dest : 32'd0);
        if (drop_offer) begin
            bus.IN_VALID   = 1'b1;
            bus.IN_PC      = 32'h40;
            bus.IN_IS_MC   = 1'b0;
            bus.IN_IS_CTRL = 1'b0;
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        chk_out({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        RST            = 1'b1;
        bus.IN_VALID   = 1'b0;
        bus.IN_PC      = '0;
        bus.IN_IS_MC   = 1'b0;
        bus.IN_IS_CTRL = 1'b0;
        bus.JUMP_DEST  = '0;
        repeat (2) @(negedge CLK);
        chk_out("rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk_out("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        run_op("alu", 32'h10, 1'b0, 1'b0, 32'h11, 1'b0, 1'b0);
        run_op("br_tk", 32'h20, 1'b0, 1'b1, 32'h08, 1'b1, 1'b1);
        run_op("br_nt", 32'h20, 1'b0, 1'b1, 32'h21, 1'b0, 1'b0);
        run_op("wrap_nt", 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        run_op("wrap_tk", 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF,
               1'b1, 1'b0);
        run_op("nonctrl", 32'h30, 1'b0, 1'b0, 32'h1234, 1'b0, 1'b0);
        run_op("mc", 32'h30, 1'b1, 1'b0, 32'h31, 1'b0, 1'b0);
        run_op("mc_tk", 32'h34, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);

        // reset while the op is still executing
        bus.IN_VALID   = 1'b1;
        bus.IN_PC      = 32'h50;
        bus.IN_IS_MC   = 1'b1;
        bus.IN_IS_CTRL = 1'b1;
        bus.JUMP_DEST  = 32'h99;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        for (int i = 0; i < RST_AT; i++) begin
            chk_out("rst_mid.ex", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            if (i < RST_AT - 1) @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        chk_out("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        RST = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            chk_out("rst_after", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        end

        // back-to-back single-cycle ops with IN_VALID held high
        bus.IN_VALID   = 1'b1;
        bus.IN_PC      = 32'h60;
        bus.IN_IS_MC   = 1'b0;
        bus.IN_IS_CTRL = 1'b0;
        bus.JUMP_DEST  = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk_out("b2b.ex", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            if (k == 2) bus.IN_VALID = 1'b0;
            @(negedge CLK);
            chk_out("b2b.done", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        @(negedge CLK);
        chk_out("b2b.idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter MC_LAT, default 4: total execute cycles of a multi-cycle op; legal range 2..16.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 IN_VALID  in  1  decoded instruction offered.
REQ-006 IN_READY  out  1  sequencer can accept an instruction this cycle.
REQ-007 IN_PC  in  32  word-addressed PC of the offered instruction.
REQ-008 IN_IS_MC  in  1  instruction is multi-cycle.
REQ-009 IN_IS_CTRL  in  1  instruction is jal/jalr/branch.
REQ-010 JUMP_DEST  in  32  next-PC from the execute datapath, combinational, valid while EXEC_EN=1.
REQ-011 EXEC_EN  out  1  execute datapath active for the held instruction.
REQ-012 OUT_VALID  out  1  one-cycle retire strobe.
REQ-013 FLUSH  out  1  one-cycle front-end flush strobe.
REQ-014 REDIRECT_PC  out  32  fetch target, valid when FLUSH=1.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, WAIT, DONE.
REQ-016 Handshake: accept iff IN_VALID && IN_READY at a rising edge; IN_READY=1 only in IDLE and DONE.
REQ-017 On accept SHALL latch IN_PC, IN_IS_MC, IN_IS_CTRL and go to EXEC.
REQ-018 EXEC: EXEC_EN=1; JUMP_DEST captured into a 32-bit register; next state WAIT if latched MC, else DONE.
REQ-019 WAIT: EXEC_EN=1; 4-bit down-counter loaded with MC_LAT-2 on EXEC->WAIT; JUMP_DEST recaptured each WAIT cycle; counter 0 -> DONE, else decrement.
REQ-020 EXEC_EN SHALL be high for exactly 1 cycle on single-cycle ops and exactly MC_LAT consecutive cycles on multi-cycle ops.
REQ-021 DONE: OUT_VALID=1 for exactly one cycle; next state EXEC if an accept occurs that cycle, else IDLE.
REQ-022 Taken = latched CTRL && captured JUMP_DEST != latched PC + 1 (32-bit wrap-around add).
REQ-023 In DONE, if taken: FLUSH=1 and REDIRECT_PC = captured JUMP_DEST.
REQ-024 Otherwise FLUSH=0 and REDIRECT_PC=0.
REQ-025 Simultaneous taken retire and new accept in DONE: the new instruction SHALL be dropped (not latched); next state IDLE.
REQ-026 Latency: accept at edge N -> OUT_VALID during cycle N+2 (single-cycle) or N+1+MC_LAT (multi-cycle).
REQ-027 Sustained throughput: one single-cycle op per 2 cycles.
REQ-028 IN_PC=32'hFFFFFFFF with JUMP_DEST=0 SHALL count as not-taken (PC+1 wraps to 0).
REQ-029 Non-CTRL instructions SHALL never raise FLUSH, whatever JUMP_DEST is.

Reset
REQ-030 RST=1 at an edge SHALL force state IDLE, counter 0, latched/captured registers 0, in any state including mid-WAIT; the in-flight op is abandoned with no OUT_VALID.
REQ-031 During and after reset: IN_READY=1, EXEC_EN=0, OUT_VALID=0, FLUSH=0, REDIRECT_PC=0.

Configuration
REQ-032 Macro EXEC_SEQ_MC_EN SHALL gate multi-cycle support.
REQ-033 When EXEC_SEQ_MC_EN is defined: the WAIT state and counter exist and MC_LAT applies.
REQ-034 When EXEC_SEQ_MC_EN is undefined: IN_IS_MC is ignored, WAIT and the counter are not built, and every op takes the single-cycle path.

Verification
REQ-035 Single ALU op, IN_PC=0x10, CTRL=0: accept at N -> EXEC_EN=1 in N+1, OUT_VALID=1 in N+2, FLUSH=0.
REQ-036 Taken branch, IN_PC=0x20, JUMP_DEST=0x08: FLUSH=1 and REDIRECT_PC=0x08 in the DONE cycle; an offer made in that cycle is not accepted.
REQ-037 Not-taken branch, IN_PC=0x20, JUMP_DEST=0x21: OUT_VALID=1, FLUSH=0.
REQ-038 MC op with MC_LAT=4, macro defined: EXEC_EN high 4 cycles, OUT_VALID at N+5, IN_READY=0 during N+1..N+4; with macro undefined, OUT_VALID at N+2.
REQ-039 RST asserted in the 2nd WAIT cycle: next cycle shows IDLE outputs; no OUT_VALID or FLUSH ever emitted for that op.
REQ-040 Back-to-back: IN_VALID held high for 3 ALU ops -> 3 OUT_VALID pulses at N+2, N+4, N+6.
